alu_exec_ctrl: RTL and testbench
================================

Name: alu_exec_ctrl

Overview:
Sequencing stage that wraps the 8-bit combinational ALU. It accepts one operation per valid/ready handshake and reads operands from a 4-entry x 8-bit register file (operand B can be an immediate instead). It drives the ALU's A/B/AluOp inputs from registers, then captures Result/Zero/Negative/Overflow back into the register file and a flag register. Completion is reported to the downstream consumer over a second valid/ready handshake.

Parameters:
NREGS, 4, number of 8-bit registers; fixed at 4, so register index fields are 2 bits.
DW, 8, datapath width; fixed to match the ALU.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operation request valid
in_ready  output  1  stage can accept an operation
in_op  input  4  AluOp code
in_rd  input  2  destination register
in_rs1  input  2  source register for ALU A
in_rs2  input  2  source register for ALU B
in_imm_en  input  1  1: B = in_imm; 0: B = reg[in_rs2]
in_imm  input  8  immediate operand
alu_a  output  8  registered ALU A operand
alu_b  output  8  registered ALU B operand
alu_op  output  4  registered ALU opcode
alu_result  input  8  ALU Result
alu_zero  input  1  ALU Zero
alu_negative  input  1  ALU Negative
alu_overflow  input  1  ALU Overflow
out_valid  output  1  completion valid
out_ready  input  1  consumer accepts completion
out_result  output  8  captured result
out_rd  output  2  destination that was written
out_err  output  1  operation was a reserved opcode
flag_z  output  1  registered Zero flag
flag_n  output  1  registered Negative flag
flag_v  output  1  registered Overflow flag
dbg_addr  input  2  debug read index
dbg_data  output  8  reg[dbg_addr], combinational

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM goes to IDLE.
  - All registers, alu_a, alu_b, alu_op, out_result, out_rd, out_err and the flags clear to 0.
  - out_valid = 0.
  - Any in-flight operation is dropped, with no write and no completion.
- FSM has three states: IDLE, EXEC, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid & in_ready at an edge, latch the operation:
    - alu_a = reg[in_rs1]
    - alu_b = in_imm_en ? in_imm : reg[in_rs2]
    - alu_op = in_op
    - in_rd is latched internally.
  - Then go to EXEC.
- EXEC (exactly one cycle):
  - in_ready = 0.
  - The ALU settles combinationally from alu_a/alu_b/alu_op.
  - At the end-of-cycle edge:
    - out_result = alu_result; out_rd = latched rd.
    - Go to DONE.
  - If alu_op is valid:
    - reg[rd] = alu_result; flag_z/n/v = alu_zero/negative/overflow.
    - out_err = 0.
  - If alu_op is reserved (4'h3, 4'h4, 4'hE, 4'hF):
    - No register write; flags hold.
    - out_err = 1.
- DONE:
  - out_valid = 1; out_result, out_rd and out_err are stable while out_ready = 0.
  - in_ready = 0; in_valid is ignored.
  - On out_valid & out_ready at an edge, go to IDLE.
- Latency and throughput:
  - Accept edge T0; write and capture at T1; out_valid is high from T1.
  - Best case: IDLE again after T2, so one operation per 3 cycles.
- Hazards: none by construction.
  - Operands are read only in IDLE.
  - Writes occur only at the EXEC edge.
  - A back-to-back dependent operation therefore sees the new value.
- alu_a, alu_b and alu_op hold their last values outside EXEC.
- Registers have no special read-only entry; reg[0] is writable.
- dbg_data reflects a write from the edge after that edge.

Test Plan:
- Load: op 4'h0, rs1=r0 (0), imm_en=1, imm=8'h7F, rd=r1, out_ready=1.
  -> out_valid at T1 for one cycle; out_result=8'h7F; reg1=8'h7F; flag_z=0, flag_n=0, flag_v=0; in_ready high again at T3.
- Signed overflow: op 4'h0, rs1=r1 (8'h7F), imm=8'h01, rd=r2.
  -> reg2=8'h80; flag_n=1; flag_v=1; flag_z=0.
- Zero result: op 4'h1, rs1=r1 (8'h7F), imm=8'h7F, rd=r3.
  -> reg3=8'h00; flag_z=1; flag_v=0.
- Reserved op: with flags from the previous step, issue op 4'hE, rd=r3.
  -> out_err=1; reg3 stays 8'h00; flags unchanged; next valid op gives out_err=0.
- Backpressure: out_ready=0 for 5 cycles after completion, in_valid held high with a new op.
  -> out_valid and out_result held constant; in_ready=0 throughout; new op accepted only after the out handshake and the return to IDLE.
- Reset mid-EXEC: assert rst_n=0 during EXEC of op 4'h0 with imm=8'h55, rd=r2.
  -> reg2=0; out_valid=0; in_ready=1 after release; no completion is ever emitted.

Source files
------------

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: sequencing stage around the 8-bit combinational ALU.
// It accepts one operation per input handshake and reads operands from a
// 4 x 8 register file, with an optional immediate for B. It captures the ALU
// result and flags one cycle later and reports completion over an output
// handshake.
module alu_exec_ctrl #(
    parameter int NREGS = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_op,
    input  logic [1:0]    in_rd,
    input  logic [1:0]    in_rs1,
    input  logic [1:0]    in_rs2,
    input  logic          in_imm_en,
    input  logic [DW-1:0] in_imm,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_op,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_zero,
    input  logic          alu_negative,
    input  logic          alu_overflow,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_result,
    output logic [1:0]    out_rd,
    output logic          out_err,
    output logic          flag_z,
    output logic          flag_n,
    output logic          flag_v,
    input  logic [1:0]    dbg_addr,
    output logic [DW-1:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;

    logic [DW-1:0] regs [NREGS];
    logic [1:0]    rd_q;

    logic          accept;
    logic          in_exec;
    logic          op_reserved;
    logic          wr_en;

    // Opcodes 3, 4, E and F have no ALU function assigned.
    function automatic logic is_reserved(input logic [3:0] op);
        logic r;
        case (op)
            4'h3, 4'h4, 4'hE, 4'hF: r = 1'b1;
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

    assign accept      = in_valid & in_ready;
    assign in_exec     = (state_q == EXEC);
    assign op_reserved = is_reserved(alu_op);
    assign wr_en       = in_exec & ~op_reserved;
    assign dbg_data    = regs[dbg_addr];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand latch. Operands are sampled only at acceptance, so they hold
    // their values at all other times.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            rd_q   <= '0;
        end else if (accept) begin
            alu_a  <= regs[in_rs1];
            alu_b  <= in_imm_en ? in_imm : regs[in_rs2];
            alu_op <= in_op;
            rd_q   <= in_rd;
        end
    end

    // Completion capture at the end of EXEC. It holds through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result <= '0;
            out_rd     <= '0;
            out_err    <= 1'b0;
        end else if (in_exec) begin
            out_result <= alu_result;
            out_rd     <= rd_q;
            out_err    <= op_reserved;
        end
    end

    // Flag register. It updates only for valid opcodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_v <= 1'b0;
        end else if (wr_en) begin
            flag_z <= alu_zero;
            flag_n <= alu_negative;
            flag_v <= alu_overflow;
        end
    end

    // Register file write port. reg[0] is an ordinary register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[rd_q] <= alu_result;
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed testbench for alu_exec_ctrl with a behavioural 8-bit ALU attached.
module tb_alu_exec_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_op;
    logic [1:0] in_rd;
    logic [1:0] in_rs1;
    logic [1:0] in_rs2;
    logic       in_imm_en;
    logic [7:0] in_imm;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_op;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       alu_negative;
    logic       alu_overflow;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic [1:0] out_rd;
    logic       out_err;
    logic       flag_z;
    logic       flag_n;
    logic       flag_v;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_exec_ctrl #(.NREGS(4), .DW(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_rd        (in_rd),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_imm_en    (in_imm_en),
        .in_imm       (in_imm),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_negative (alu_negative),
        .alu_overflow (alu_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_rd       (out_rd),
        .out_err      (out_err),
        .flag_z       (flag_z),
        .flag_n       (flag_n),
        .flag_v       (flag_v),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    // Behavioural ALU: 0 ADD, 1 SUB, 2 AND, anything else XOR.
    always_comb begin
        alu_overflow = 1'b0;
        case (alu_op)
            4'h0: begin
                alu_result   = alu_a + alu_b;
                alu_overflow = (alu_a[7] == alu_b[7]) && (alu_result[7] != alu_a[7]);
            end
            4'h1: begin
                alu_result   = alu_a - alu_b;
                alu_overflow = (alu_a[7] != alu_b[7]) && (alu_result[7] != alu_a[7]);
            end
            4'h2:    alu_result = alu_a & alu_b;
            default: alu_result = alu_a ^ alu_b;
        endcase
        alu_zero     = (alu_result == 8'h00);
        alu_negative = alu_result[7];
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input logic [1:0] idx, input logic [7:0] exp);
        dbg_addr = idx;
        #1;
        chk($sformatf("reg%0d", idx), dbg_data, exp);
    endtask

    task automatic chk_flags(input logic z, input logic n, input logic v);
        chk("flag_z", flag_z, z);
        chk("flag_n", flag_n, n);
        chk("flag_v", flag_v, v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for out_valid and requires it exactly one edge after EXEC.
    task automatic wait_done();
        int n = 0;
        while (out_valid !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        chk("done_latency", 8'(n), 8'd1);
    endtask

    // Issues one op from IDLE and checks the EXEC-cycle operands. If out_ready
    // is high, it also checks the return to IDLE one cycle after completion.
    task automatic run_op(input logic [3:0] op, input logic [1:0] rd,
                          input logic [1:0] rs1, input logic [1:0] rs2,
                          input logic imm_en, input logic [7:0] imm,
                          input logic [7:0] exp_a, input logic [7:0] exp_b);
        chk("in_ready_idle", in_ready, 1'b1);
        in_valid  = 1'b1;
        in_op     = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm_en = imm_en;
        in_imm    = imm;
        step();
        in_valid = 1'b0;
        chk("in_ready_exec", in_ready, 1'b0);
        chk("out_valid_exec", out_valid, 1'b0);
        chk("alu_a", alu_a, exp_a);
        chk("alu_b", alu_b, exp_b);
        chk("alu_op", alu_op, op);
        wait_done();
        chk("out_rd", out_rd, rd);
        if (out_ready) begin
            step();
            chk("out_valid_drop", out_valid, 1'b0);
            chk("in_ready_back", in_ready, 1'b1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_rd     = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_imm_en = 1'b0;
        in_imm    = '0;
        out_ready = 1'b1;
        dbg_addr  = '0;
        #12;

        // Reset state
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_alu_a", alu_a, 8'h00);
        chk("rst_alu_b", alu_b, 8'h00);
        chk("rst_alu_op", alu_op, 8'h00);
        chk("rst_out_result", out_result, 8'h00);
        chk("rst_out_err", out_err, 1'b0);
        chk_flags(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) chk_reg(2'(i), 8'h00);
        rst_n = 1'b1;
        step();

        // Load: 0 + 7F -> r1
        run_op(4'h0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h7F, 8'h00, 8'h7F);
        chk("load_result", out_result, 8'h7F);
        chk("load_err", out_err, 1'b0);
        chk_flags(1'b0, 1'b0, 1'b0);
        chk_reg(2'd1, 8'h7F);

        // Signed overflow: 7F + 01 -> r2
        run_op(4'h0, 2'd2, 2'd1, 2'd0, 1'b1, 8'h01, 8'h7F, 8'h01);
        chk("ovf_result", out_result, 8'h80);
        chk_flags(1'b0, 1'b1, 1'b1);
        chk_reg(2'd2, 8'h80);

        // Zero: 7F - 7F -> r3
        run_op(4'h1, 2'd3, 2'd1, 2'd0, 1'b1, 8'h7F, 8'h7F, 8'h7F);
        chk("zero_result", out_result, 8'h00);
        chk_flags(1'b1, 1'b0, 1'b0);
        chk_reg(2'd3, 8'h00);

        // Reserved op E: ALU gives 7F ^ 10 = 6F, but nothing is written
        run_op(4'hE, 2'd3, 2'd1, 2'd0, 1'b1, 8'h10, 8'h7F, 8'h10);
        chk("rsv_err", out_err, 1'b1);
        chk("rsv_result", out_result, 8'h6F);
        chk_flags(1'b1, 1'b0, 1'b0);
        chk_reg(2'd3, 8'h00);

        // Valid op after reserved, register B source, r0 as destination: 80 & 80
        run_op(4'h2, 2'd0, 2'd2, 2'd2, 1'b0, 8'hFF, 8'h80, 8'h80);
        chk("and_err", out_err, 1'b0);
        chk("and_result", out_result, 8'h80);
        chk_flags(1'b0, 1'b1, 1'b0);
        chk_reg(2'd0, 8'h80);

        // Backpressure: r0(80) + 01 -> r1 with out_ready low
        out_ready = 1'b0;
        run_op(4'h0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h01, 8'h80, 8'h01);
        chk("bp_result", out_result, 8'h81);
        // Dependent op r1 + 01 -> r3 is held on the input during DONE
        in_valid  = 1'b1;
        in_op     = 4'h0;
        in_rd     = 2'd3;
        in_rs1    = 2'd1;
        in_imm_en = 1'b1;
        in_imm    = 8'h01;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_hold_result", out_result, 8'h81);
            chk("bp_hold_rd", out_rd, 8'd1);
        end
        out_ready = 1'b1;
        step();
        chk("bp_idle_ready", in_ready, 1'b1);
        chk("bp_idle_valid", out_valid, 1'b0);
        chk_reg(2'd1, 8'h81);
        step();
        in_valid = 1'b0;
        chk("dep_alu_a", alu_a, 8'h81);
        chk("dep_alu_b", alu_b, 8'h01);
        wait_done();
        chk("dep_result", out_result, 8'h82);
        chk("dep_rd", out_rd, 8'd3);
        chk_flags(1'b0, 1'b1, 1'b0);
        chk_reg(2'd3, 8'h82);
        step();

        // Reset mid-EXEC: r0 + 55 -> r2, then it is dropped
        chk("pre_rst_ready", in_ready, 1'b1);
        in_valid  = 1'b1;
        in_op     = 4'h0;
        in_rd     = 2'd2;
        in_rs1    = 2'd0;
        in_imm_en = 1'b1;
        in_imm    = 8'h55;
        step();
        in_valid = 1'b0;
        chk("mid_exec_ready", in_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mr_out_valid", out_valid, 1'b0);
        chk("mr_in_ready", in_ready, 1'b1);
        chk_reg(2'd2, 8'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("mr_no_done", out_valid, 1'b0);
            chk("mr_ready", in_ready, 1'b1);
        end
        chk_reg(2'd2, 8'h00);
        chk_reg(2'd0, 8'h00);
        chk_flags(1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
